// File: rtl/stack_pkg.sv
// Shared opcode encodings, FSM state codes and a small opcode helper for the LIFO stack.
package stack_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_PUSH  = 2'b00;
    localparam op_t OP_POP   = 2'b01;
    localparam op_t OP_PEEK  = 2'b10;
    localparam op_t OP_CLEAR = 2'b11;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Pop and peek both read the top-of-stack word.
    function automatic logic is_read(input op_t op);
        return (op == OP_POP) || (op == OP_PEEK);
    endfunction

endpackage

// File: rtl/param_lifo_stack_if.sv
// Request/response bus of the LIFO stack plus its status flags and an FSM state debug tap.
interface param_lifo_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a request is taken on a rising edge with req_valid && req_ready; the requester
    // holds req_valid/req_op/req_data until then. rsp_valid is a one-cycle pulse, no back-pressure.
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf_sticky;
    logic             udf_sticky;
    logic [1:0]       dbg_state;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, count, empty, full,
               ovf_sticky, udf_sticky, dbg_state
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, count, empty, full,
               ovf_sticky, udf_sticky, dbg_state
    );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x WIDTH storage array: one write port, one registered read port, contents never reset.
module stack_mem #(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 16,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack: IDLE -> EXEC -> RESP per request, with guarded push/pop/peek/clear.
module param_lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    param_lifo_stack_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    sp;
    logic             empty_q;
    logic             full_q;
    logic             ovf_q;
    logic             udf_q;
    logic             err_q;
    logic             rd_ok_q;
    logic [WIDTH-1:0] rd_data;
    logic             do_write;
    logic             do_read;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;

    // Memory strobes fire only in EXEC and only when the guard allows the access.
    assign do_write = (state == ST_EXEC) && (op_q == OP_PUSH) && !full_q;
    assign do_read  = (state == ST_EXEC) && is_read(op_q) && !empty_q;
    assign waddr    = AW'(sp);
    assign raddr    = AW'(sp - CW'(1));

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_write),
        .waddr (waddr),
        .wdata (data_q),
        .re    (do_read),
        .raddr (raddr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_PUSH;
            data_q  <= '0;
            sp      <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.req_op;
                        data_q <= bus.req_data;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state   <= ST_RESP;
                    err_q   <= 1'b0;
                    rd_ok_q <= 1'b0;
                    case (op_q)
                        OP_PUSH: begin
                            if (full_q) begin
                                err_q <= 1'b1;
                                ovf_q <= 1'b1;
                            end else begin
                                sp      <= sp + CW'(1);
                                empty_q <= 1'b0;
                                full_q  <= (sp + CW'(1)) == CW'(DEPTH);
                            end
                        end
                        OP_POP: begin
                            if (empty_q) begin
                                err_q <= 1'b1;
                                udf_q <= 1'b1;
                            end else begin
                                sp      <= sp - CW'(1);
                                full_q  <= 1'b0;
                                empty_q <= sp == CW'(1);
                                rd_ok_q <= 1'b1;
                            end
                        end
                        OP_PEEK: begin
                            if (empty_q) begin
                                err_q <= 1'b1;
                                udf_q <= 1'b1;
                            end else begin
                                rd_ok_q <= 1'b1;
                            end
                        end
                        default: begin
                            sp      <= '0;
                            empty_q <= 1'b1;
                            full_q  <= 1'b0;
                            ovf_q   <= 1'b0;
                            udf_q   <= 1'b0;
                        end
                    endcase
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The read register only changes on a successful read, so rsp_data holds between responses.
    assign bus.rsp_data   = rd_ok_q ? rd_data : '0;
    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.rsp_valid  = (state == ST_RESP);
    assign bus.rsp_err    = err_q;
    assign bus.count      = sp;
    assign bus.empty      = empty_q;
    assign bus.full       = full_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.udf_sticky = udf_q;
    assign bus.dbg_state  = state;

endmodule

// File: doc/param_lifo_stack.md
Name: param_lifo_stack

Overview:
Parametrised successor to the 8-bit x 16 TinyTapeout stack. Configurable data width and depth. Uses a request/response handshake with four opcodes: push, pop, peek and clear. Reports full, empty and occupancy, and raises per-request and sticky overflow/underflow errors. Sits between the top-level pin wrapper and the user I/O bus; the wrapper maps pins onto the request/response ports.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of two)
AW, $clog2(DEPTH), derived pointer width; localparam, not overridable
CW, $clog2(DEPTH+1), derived count width; localparam, not overridable

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_op  in  2  00 push, 01 pop, 10 peek, 11 clear
req_data  in  WIDTH  push data
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  WIDTH  popped/peeked word; 0 for push/clear/error
rsp_err  out  1  qualifies rsp_valid: request failed
count  out  CW  current occupancy
empty  out  1  count == 0
full  out  1  count == DEPTH
ovf_sticky  out  1  a push was attempted while full
udf_sticky  out  1  a pop or peek was attempted while empty

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (port names clk, rst).
- Reset values: state IDLE, sp/count 0, req_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0, both sticky flags 0, empty 1, full 0. Memory contents are not reset.
- Reset mid-operation: any in-flight request is abandoned and no rsp_valid is produced. The next edge after rst deasserts starts in IDLE.
- Accept: request accepted on a rising edge when req_valid && req_ready. req_op and req_data are sampled only at accept.
- FSM states:
  - IDLE: req_ready=1. Accept moves to EXEC.
  - EXEC: req_ready=0. Performs the memory access and pointer update. Always moves to RESP.
  - RESP: req_ready=0. rsp_valid=1 for exactly this cycle. Moves to IDLE.
- Latency: rsp_valid is high in the second cycle after the accept edge. Maximum throughput is one request per 3 cycles.
- push:
  - Not full: in EXEC write mem[sp]=data; sp and count +1 at the EXEC edge; rsp_err=0.
  - Full: no write, no pointer change, rsp_err=1, ovf_sticky set.
- pop:
  - Not empty: in EXEC, sp-1, count-1, registered read of mem[sp-1]; rsp_data=that word.
  - Empty: rsp_err=1, rsp_data=0, udf_sticky set, no change.
- peek: same as pop but sp and count unchanged. Empty gives rsp_err=1 and sets udf_sticky.
- clear: sp and count set to 0; ovf_sticky and udf_sticky cleared; rsp_data=0; rsp_err=0. Memory is untouched.
- Pointer arithmetic: sp is in [0, DEPTH]; there is no wrap-around. Pointer changes happen only through the guarded cases above.
- Status: count, empty and full are registered. They update on the EXEC edge, so they are visible in the RESP cycle.
- rsp_data and rsp_err hold their values outside RESP. Consumers qualify them with rsp_valid.
- req_valid asserted while req_ready=0 is ignored, not queued. The requester holds it until accepted.

Decomposition:
- stack_pkg holds:
  - op encoding constants (OP_PUSH, OP_POP, OP_PEEK, OP_CLEAR);
  - the FSM state enum (ST_IDLE, ST_EXEC, ST_RESP).
- Sub-module stack_mem: DEPTH x WIDTH register array, one write port, one registered read port, no reset. Instantiated once.
- Control, pointer and flag logic live in param_lifo_stack.

Test Plan (WIDTH=8, DEPTH=4 unless noted):
1. Reset, then push 0x11, 0x22, 0x33 -> each response has rsp_err=0 and rsp_data=0; count=3; empty=0, full=0. Three pops -> 0x33, 0x22, 0x11 (LIFO); empty=1.
2. Push 4 words, then push 0x55 -> full=1 from the fourth RESP; fifth response has rsp_err=1; ovf_sticky=1; count stays 4. Pop then returns the fourth word, not 0x55.
3. From empty, pop, then peek -> both responses have rsp_err=1 and rsp_data=0; udf_sticky=1; count=0. Clear -> rsp_err=0; both sticky flags 0.
4. Push 0xA5, peek twice -> both 0xA5 with count=1. Pop -> 0xA5, count=0. Check rsp_valid is high exactly 2 cycles after each accept and req_ready is low for 2 cycles.
5. Hold req_valid high for 3 consecutive pushes -> exactly one accept per IDLE cycle; no extra writes during EXEC/RESP.
6. Assert rst during EXEC of a pop with count=2 -> no rsp_valid; count=0; empty=1; sticky flags 0. Repeat with DEPTH=5, WIDTH=12: fill to 5, full=1, overflow on the sixth push.
